// File: rtl/fp_cvt_multi.sv
// Multi-channel float-to-integer converter: per-channel request queues, round-robin issue,
// and a two-stage unpack/align + round/saturate pipeline.
module fp_cvt_multi #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic [2:0]        rm,
  input  logic [NCH-1:0]    in_en,
  output logic [NCH-1:0]    in_rdy,
  input  logic [NCH*64-1:0] in_A,
  input  logic [NCH*3-1:0]  in_mode,
  output logic [63:0]       res,
  output logic              res_vld,
  output logic [1:0]        res_ch,
  output logic              res_inv,
  output logic              res_inx
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [63:0]    q_a      [NCH][QDEPTH];
  logic [2:0]     q_mode   [NCH][QDEPTH];
  logic [PW-1:0]  wr_ptr_q [NCH];
  logic [PW-1:0]  rd_ptr_q [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [1:0]     last_grant_q;

  logic [NCH-1:0] nonempty, acc, pop;
  logic           grant_vld, issue;
  logic [1:0]     grant, cand;
  logic [63:0]    head_a;
  logic [2:0]     head_mode;

  // Ready depends only on registered occupancy, so a full queue refuses even while popping.
  always_comb begin
    nonempty = '0;
    in_rdy   = '0;
    acc      = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      nonempty[c] = cnt_q[c] != '0;
      in_rdy[c]   = cnt_q[c] != CW'(QDEPTH);
      acc[c]      = in_en[c] & in_rdy[c] & clkEn;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = last_grant_q;
    for (int k = 0; k < int'(NCH); k++) begin
      cand = (cand == 2'(NCH - 1)) ? 2'd0 : cand + 2'd1;
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign issue     = clkEn & grant_vld;
  assign head_a    = q_a[grant][rd_ptr_q[grant]];
  assign head_mode = q_mode[grant][rd_ptr_q[grant]];

  always_comb begin
    pop = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      pop[c] = issue && (grant == 2'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(NCH); c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      last_grant_q <= 2'(NCH - 1);
    end else begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (acc[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PW'(1);
        if (pop[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
        cnt_q[c] <= cnt_q[c] + CW'(acc[c]) - CW'(pop[c]);
      end
      if (issue) last_grant_q <= grant;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NCH); c++) begin
      if (acc[c]) begin
        q_a[c][wr_ptr_q[c]]    <= in_A[c*64 +: 64];
        q_mode[c][wr_ptr_q[c]] <= in_mode[c*3 +: 3];
      end
    end
  end

  // Stage 1: unpack and align into 64 integer bits plus guard and sticky.
  logic [10:0]  ef;
  logic [51:0]  frac52;
  logic         raw_sign, max_exp;
  int           unb_exp;
  logic [127:0] wide;
  logic         u_sign, u_g, u_s, u_bad;
  logic [63:0]  u_mag;

  always_comb begin
    u_sign = 1'b0;
    u_mag  = '0;
    u_g    = 1'b0;
    u_s    = 1'b0;
    u_bad  = 1'b0;
    wide   = '0;
    if (head_mode[0]) begin
      ef       = head_a[62:52];
      frac52   = head_a[51:0];
      raw_sign = head_a[63];
      max_exp  = &head_a[62:52];
      unb_exp  = int'(ef) - 1023;
    end else begin
      ef       = {3'b000, head_a[30:23]};
      frac52   = {head_a[22:0], 29'b0};
      raw_sign = head_a[31];
      max_exp  = &head_a[30:23];
      unb_exp  = int'(ef) - 127;
    end
    if (head_mode[2]) begin
      u_mag = head_a;
    end else begin
      u_sign = raw_sign;
      if (max_exp) begin
        u_bad = 1'b1;
      end else if (ef == '0) begin
        u_s = |frac52;  // denormal: below one half, only sticky survives
      end else if (unb_exp < -1) begin
        u_s = 1'b1;
      end else if (unb_exp > 63) begin
        u_bad = 1'b1;
      end else begin
        wide  = {75'b0, 1'b1, frac52} << (unb_exp + 12);
        u_mag = wide[127:64];
        u_g   = wide[63];
        u_s   = |wide[62:0];
      end
    end
  end

  logic        v1_q, sign1_q, g1_q, s1_q, bad1_q, is32b1_q, verb1_q;
  logic [1:0]  ch1_q, rm1_q;
  logic [63:0] mag1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      ch1_q    <= '0;
      rm1_q    <= '0;
      is32b1_q <= 1'b0;
      verb1_q  <= 1'b0;
      sign1_q  <= 1'b0;
      mag1_q   <= '0;
      g1_q     <= 1'b0;
      s1_q     <= 1'b0;
      bad1_q   <= 1'b0;
    end else if (clkEn) begin
      v1_q <= issue;
      if (issue) begin
        ch1_q    <= grant;
        rm1_q    <= rm[2] ? 2'd0 : rm[1:0];
        is32b1_q <= head_mode[1];
        verb1_q  <= head_mode[2];
        sign1_q  <= u_sign;
        mag1_q   <= u_mag;
        g1_q     <= u_g;
        s1_q     <= u_s;
        bad1_q   <= u_bad;
      end
    end
  end

  // Stage 2: round magnitude, range-check against target width, apply sign.
  logic        rinc, oor;
  logic [64:0] sum, lim;
  logic [63:0] minv, res_d;
  logic        inv_d, inx_d;

  always_comb begin
    case (rm1_q)
      2'd0:    rinc = g1_q & (s1_q | mag1_q[0]);
      2'd1:    rinc = 1'b0;
      2'd2:    rinc = sign1_q & (g1_q | s1_q);
      default: rinc = ~sign1_q & (g1_q | s1_q);
    endcase
    sum   = {1'b0, mag1_q} + {64'b0, rinc};
    lim   = is32b1_q ? (65'd1 << 31) : (65'd1 << 63);
    oor   = sign1_q ? (sum > lim) : (sum >= lim);
    minv  = is32b1_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    res_d = '0;
    inv_d = 1'b0;
    inx_d = 1'b0;
    if (verb1_q) begin
      res_d = mag1_q;
    end else if (bad1_q || oor) begin
      res_d = minv;
      inv_d = 1'b1;
    end else begin
      res_d = sign1_q ? -sum[63:0] : sum[63:0];
      inx_d = g1_q | s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld <= 1'b0;
      res     <= '0;
      res_ch  <= '0;
      res_inv <= 1'b0;
      res_inx <= 1'b0;
    end else if (clkEn) begin
      res_vld <= v1_q;
      if (v1_q) begin
        res     <= res_d;
        res_ch  <= ch1_q;
        res_inv <= inv_d;
        res_inx <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_cvt_multi.sv
// Directed self-checking bench for fp_cvt_multi: conversions, arbitration, stalls and reset.
module tb_fp_cvt_multi;

  localparam int unsigned NCH    = 3;
  localparam int unsigned QDEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clkEn;
  logic [2:0]        rm;
  logic [NCH-1:0]    in_en;
  logic [NCH-1:0]    in_rdy;
  logic [NCH*64-1:0] in_A;
  logic [NCH*3-1:0]  in_mode;
  logic [63:0]       res;
  logic              res_vld;
  logic [1:0]        res_ch;
  logic              res_inv;
  logic              res_inx;

  fp_cvt_multi #(.NCH(NCH), .QDEPTH(QDEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .clkEn   (clkEn),
    .rm      (rm),
    .in_en   (in_en),
    .in_rdy  (in_rdy),
    .in_A    (in_A),
    .in_mode (in_mode),
    .res     (res),
    .res_vld (res_vld),
    .res_ch  (res_ch),
    .res_inv (res_inv),
    .res_inx (res_inx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    logic [1:0]  ch;
    logic        inv;
    logic        inx;
    int          cyc;
  } res_t;

  res_t mq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream consumer: takes a result only in enabled cycles.
  always @(negedge clk) begin
    if (!rst && clkEn && res_vld) mq.push_back('{res, res_ch, res_inv, res_inx, cyc});
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic get_res(output res_t r, output logic ok);
    int n = 0;
    while (mq.size() == 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = mq.size() != 0;
    if (ok) r = mq.pop_front();
  endtask

  task automatic convert(input string tag, input int ch, input logic [63:0] a,
                         input logic [2:0] mode, input logic [2:0] rmv, input logic [63:0] exp_v,
                         input logic exp_inv, input logic exp_inx);
    res_t r;
    logic ok;
    int   acc_cyc;
    @(posedge clk);
    #1;
    rm                 = rmv;
    in_en              = '0;
    in_en[ch]          = 1'b1;
    in_A[ch*64 +: 64]  = a;
    in_mode[ch*3 +: 3] = mode;
    acc_cyc            = cyc;
    @(posedge clk);
    #1;
    in_en = '0;
    get_res(r, ok);
    check_val({tag, "_present"}, 64'(ok), 64'd1);
    if (ok) begin
      check_val({tag, "_res"}, r.v, exp_v);
      check_val({tag, "_ch"}, 64'(r.ch), 64'(ch));
      check_val({tag, "_inv"}, 64'(r.inv), 64'(exp_inv));
      check_val({tag, "_inx"}, 64'(r.inx), 64'(exp_inx));
      check_val({tag, "_lat"}, 64'(r.cyc - acc_cyc), 64'd3);
    end
  endtask

  task automatic burst_load(input logic [63:0] base);
    @(posedge clk);
    #1;
    in_en = '1;
    for (int k = 0; k < int'(QDEPTH); k++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        in_A[c*64 +: 64]  = base + 64'(c * 16 + k);
        in_mode[c*3 +: 3] = 3'b100;
      end
      if (k < int'(QDEPTH) - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   b0;
    int   first;
    rst     = 1'b1;
    clkEn   = 1'b1;
    rm      = '0;
    in_en   = '0;
    in_A    = '0;
    in_mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_rdy", 64'(in_rdy), 64'b111);
    check_val("rst_vld", 64'(res_vld), 64'd0);
    check_val("rst_res", res, 64'd0);
    check_val("rst_ch", 64'(res_ch), 64'd0);
    check_val("rst_inv", 64'(res_inv), 64'd0);
    check_val("rst_inx", 64'(res_inx), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    convert("d1p5",    0, 64'h3FF8000000000000, 3'b001, 3'd0, 64'd2, 1'b0, 1'b1);
    convert("d2p5",    0, 64'h4004000000000000, 3'b001, 3'd0, 64'd2, 1'b0, 1'b1);
    convert("sm1p5rd", 1, 64'h00000000BFC00000, 3'b010, 3'd2, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1);
    convert("sm1p5rz", 1, 64'h00000000BFC00000, 3'b010, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    convert("sm1p5ru", 1, 64'h00000000BFC00000, 3'b010, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    convert("dnan32",  2, 64'h7FF8000000000001, 3'b011, 3'd0, 64'hFFFFFFFF80000000, 1'b1, 1'b0);
    convert("d2p63",   2, 64'h43E0000000000000, 3'b001, 3'd0, 64'h8000000000000000, 1'b1, 1'b0);
    convert("dm2p63",  0, 64'hC3E0000000000000, 3'b001, 3'd0, 64'h8000000000000000, 1'b0, 1'b0);
    convert("sm2p31",  1, 64'h00000000CF000000, 3'b010, 3'd0, 64'hFFFFFFFF80000000, 1'b0, 1'b0);
    convert("s2p31",   1, 64'h000000004F000000, 3'b010, 3'd0, 64'hFFFFFFFF80000000, 1'b1, 1'b0);
    convert("dnegz",   2, 64'h8000000000000000, 3'b001, 3'd0, 64'd0, 1'b0, 1'b0);
    convert("verb",    0, 64'h123456789ABCDEF0, 3'b100, 3'd0, 64'h123456789ABCDEF0, 1'b0, 1'b0);
    convert("sdenru",  0, 64'h0000000000000001, 3'b000, 3'd3, 64'd1, 1'b0, 1'b1);
    convert("sdenrd",  1, 64'h0000000080000001, 3'b000, 3'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    convert("sdenne",  2, 64'h0000000000000001, 3'b000, 3'd0, 64'd0, 1'b0, 1'b1);
    convert("sinf32",  0, 64'h000000007F800000, 3'b010, 3'd0, 64'hFFFFFFFF80000000, 1'b1, 1'b0);
    convert("dhalf",   0, 64'h3FE0000000000000, 3'b001, 3'd0, 64'd0, 1'b0, 1'b1);
    convert("d3p5",    0, 64'h400C000000000000, 3'b001, 3'd0, 64'd4, 1'b0, 1'b1);
    convert("dedgene", 1, 64'h41DFFFFFFFE00000, 3'b011, 3'd0, 64'hFFFFFFFF80000000, 1'b1, 1'b0);
    convert("dedgerz", 1, 64'h41DFFFFFFFE00000, 3'b011, 3'd1, 64'h000000007FFFFFFF, 1'b0, 1'b1);
    convert("rm5ne",   2, 64'h3FF8000000000000, 3'b001, 3'd5, 64'd2, 1'b0, 1'b1);
    convert("sm2p5",   2, 64'h00000000C0200000, 3'b000, 3'd0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1);

    // Stall with two requests in flight.
    repeat (4) @(posedge clk);
    mq.delete();
    #1;
    in_en              = 3'b001;
    in_A[63:0]         = 64'hAAAA0001;
    in_mode[2:0]       = 3'b100;
    @(posedge clk);
    #1;
    in_A[63:0]         = 64'hAAAA0002;
    @(posedge clk);
    #1;
    in_en = '0;
    @(posedge clk);
    #1;
    clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_vld", 64'(res_vld), 64'd1);
      check_val("stall_res", res, 64'hAAAA0001);
      @(posedge clk);
    end
    #1;
    check_val("stall_none_taken", 64'(mq.size()), 64'd0);
    clkEn = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_val("stall_count", 64'(mq.size()), 64'd2);
    if (mq.size() == 2) begin
      check_val("stall_r0", mq[0].v, 64'hAAAA0001);
      check_val("stall_r1", mq[1].v, 64'hAAAA0002);
      check_val("stall_gap", 64'(mq[1].cyc - mq[0].cyc), 64'd1);
    end

    // Reset while queues hold work.
    mq.delete();
    burst_load(64'hC000);
    @(posedge clk);
    #1;
    in_en = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    check_val("mrst_vld", 64'(res_vld), 64'd0);
    check_val("mrst_rdy", 64'(in_rdy), 64'b111);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("mrst_stale", 64'(mq.size()), 64'd0);
    check_val("mrst_rdy_after", 64'(in_rdy), 64'b111);

    // Burst on all channels right after reset: grants start at channel 0.
    mq.delete();
    burst_load(64'hB000);
    b0 = cyc - 1;
    @(negedge clk);
    check_val("burst_rdy_b1", 64'(in_rdy), 64'b111);
    @(posedge clk);
    #1;
    in_en = '0;
    @(negedge clk);
    check_val("burst_rdy_b2", 64'(in_rdy), 64'b001);
    @(negedge clk);
    check_val("burst_rdy_b3", 64'(in_rdy), 64'b011);
    @(negedge clk);
    check_val("burst_rdy_b4", 64'(in_rdy), 64'b111);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_val("burst_count", 64'(mq.size()), 64'd6);
    if (mq.size() == 6) begin
      first = mq[0].cyc;
      check_val("burst_first_cyc", 64'(first - b0), 64'd3);
      for (int i = 0; i < 6; i++) begin
        r = mq[i];
        check_val($sformatf("burst%0d_ch", i), 64'(r.ch), 64'(i % 3));
        check_val($sformatf("burst%0d_res", i), r.v, 64'hB000 + 64'((i % 3) * 16 + i / 3));
        check_val($sformatf("burst%0d_cyc", i), 64'(r.cyc - first), 64'(i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
